// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the round-robin arbiter: FSM state
//                type and default sizing constants.
//  Contents    : state_t            - arbiter FSM state (IDLE, BUSY)
//                c_WIDTH_DEFAULT    - default number of requesters
//                c_MAX_HOLD_DEFAULT - default ownership timeout in cycles
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int c_WIDTH_DEFAULT    = 4;
  localparam int c_MAX_HOLD_DEFAULT = 16;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/round_robin_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter_if
//  Description : Request/grant bundle between requesters and the arbiter.
//  Signals     : req       - per-requester request level
//                done      - single-cycle release pulse from current owner
//                gnt       - one-hot grant, zero when no owner
//                gnt_valid - high while any gnt bit is set
//                gnt_id    - binary index of owner, 0 when idle
//  Modports    : master - requester side (drives req/done)
//                slave  - arbiter side (drives gnt/gnt_valid/gnt_id)
//  Revision    : 1.0 - initial release
// ============================================================================
interface round_robin_arbiter_if
  import arb_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) ();

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] req;
  logic             done;
  logic [WIDTH-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id
  );

endinterface : round_robin_arbiter_if
`default_nettype wire

// File: rtl/lsb_priority_enc.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_priority_enc
//  Description : Lowest-set-bit priority encoder with one-hot output.
//  Ports       : i_vec    - input request vector
//                o_onehot - one-hot copy of the lowest set bit of i_vec
//                o_found  - high when i_vec has any bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_priority_enc #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] i_vec,
  output logic      [WIDTH-1:0] o_onehot,
  output logic                  o_found
);

  // Two's-complement trick: v & -v isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
  assign o_found  = |i_vec;

endmodule : lsb_priority_enc
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter
//  Description : Round-robin arbiter with registered one-hot grant. A grant
//                is held until the owner pulses done or drops its request;
//                a dead cycle always separates consecutive grants.
//  Ports       : clk - clock, rising edge
//                rst - synchronous active-high reset
//                bus - round_robin_arbiter_if.slave (req, done, gnt,
//                      gnt_valid, gnt_id)
//  Parameters  : WIDTH    - number of requesters (2..32)
//                MAX_HOLD - ownership timeout in cycles
//  Config      : `define RR_ARB_TIMEOUT_EN to add a hold counter that forces
//                a release after MAX_HOLD cycles of ownership.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = c_WIDTH_DEFAULT,
  parameter int MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
  input wire logic              clk,
  input wire logic              rst,
  round_robin_arbiter_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("round_robin_arbiter: WIDTH must be in 2..32");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("round_robin_arbiter: MAX_HOLD must be at least 1");
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]    r_id, w_id_nxt;
  logic             r_valid, w_valid_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;

  logic [WIDTH-1:0] w_above;
  logic [WIDTH-1:0] w_masked;
  logic [WIDTH-1:0] w_oh_m, w_oh_u, w_win_oh;
  logic             w_found_m, w_found_u;
  logic [IW-1:0]    w_win_id;
  logic             w_release;

  // Bit g is eligible in the masked pass only if it sits strictly above the
  // previous owner, which is what rotates priority.
  for (genvar g = 0; g < WIDTH; g++) begin : g_mask
    assign w_above[g] = (int'(r_ptr) < g);
  end

  assign w_masked = bus.req & w_above;

  lsb_priority_enc #(.WIDTH(WIDTH)) u_enc_masked (
    .i_vec    (w_masked),
    .o_onehot (w_oh_m),
    .o_found  (w_found_m)
  );

  lsb_priority_enc #(.WIDTH(WIDTH)) u_enc_unmasked (
    .i_vec    (bus.req),
    .o_onehot (w_oh_u),
    .o_found  (w_found_u)
  );

  // Nothing above the pointer: wrap to the lowest requester overall.
  assign w_win_oh = w_found_m ? w_oh_m : w_oh_u;

  always_comb begin
    w_win_id = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_win_oh[i]) w_win_id = IW'(i);
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          w_timeout;

  // r_hold counts completed BUSY cycles, so hitting MAX_HOLD-1 here means
  // this edge closes the MAX_HOLD-th cycle of ownership.
  assign w_timeout = (r_hold == HW'(MAX_HOLD - 1));
  assign w_release = bus.done || !bus.req[r_id] || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_hold <= '0;
    else     r_hold <= w_hold_nxt;
  end

  always_comb begin
    w_hold_nxt = r_hold;
    if (r_state == IDLE)  w_hold_nxt = '0;
    else if (!w_timeout)  w_hold_nxt = r_hold + HW'(1);
  end
`else
  assign w_release = bus.done || !bus.req[r_id];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= IW'(WIDTH - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_id    <= w_id_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_id;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        // done is meaningless without an owner and is ignored here.
        if (w_found_u) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_win_oh;
          w_id_nxt    = w_win_id;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_win_id;
        end
      end
      BUSY: begin
        // Returning to IDLE with gnt cleared creates the dead cycle.
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_id_nxt    = '0;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_id_nxt    = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_id;
  assign bus.gnt_valid = r_valid;

endmodule : round_robin_arbiter
`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_robin_arbiter
//  Description : Self-checking bench for round_robin_arbiter: directed
//                scenarios followed by randomized traffic, all compared
//                against a behavioural ownership model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter;

  localparam int W = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
  localparam bit TIMEOUT  = 1'b1;
`else
  localparam int MAX_HOLD = 16;
  localparam bit TIMEOUT  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  round_robin_arbiter_if #(.WIDTH(W)) bus ();

  round_robin_arbiter #(
    .WIDTH    (W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the resource (-1 = nobody), last owner, cycles owned.
  int m_owner;
  int m_ptr;
  int m_hold;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [W-1:0] q,
                              input logic d);
    int  c;
    bit  hit;
    if (r) begin
      m_owner = -1;
      m_ptr   = W - 1;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      // Scan forward from the requester after the last owner.
      hit = 1'b0;
      for (int k = 1; k <= W; k++) begin
        c = (m_ptr + k) % W;
        if (!hit && q[c]) begin
          hit     = 1'b1;
          m_owner = c;
        end
      end
      if (hit) begin
        m_ptr  = m_owner;
        m_hold = 0;
      end
    end else begin
      m_hold++;
      if (d || !q[m_owner] || (TIMEOUT && m_hold >= MAX_HOLD)) m_owner = -1;
    end
  endtask

  // Apply inputs for one edge, then compare outputs half a cycle later.
  task automatic step(input logic r, input logic [W-1:0] q, input logic d);
    logic [W-1:0] e_gnt;
    rst      = r;
    bus.req  = q;
    bus.done = d;
    model_update(r, q, d);
    @(posedge clk);
    @(negedge clk);
    e_gnt = (m_owner < 0) ? '0 : W'(1) << m_owner;
    check_eq("gnt",       32'(bus.gnt),       32'(e_gnt));
    check_eq("gnt_id",    32'(bus.gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_eq("gnt_valid", 32'(bus.gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check_eq("onehot0",   32'($onehot0(bus.gnt)), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    m_owner  = -1;
    m_ptr    = W - 1;
    m_hold   = 0;
    @(negedge clk);

    // Reset with everyone requesting; first grant goes to index 0.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
    step(1'b0, 4'b1111, 1'b0);
    check_eq("first_gnt", 32'(bus.gnt), 32'h1);
    check_eq("first_id",  32'(bus.gnt_id), 32'h0);

    // Rotation with done pulsed in every owned cycle.
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      check_eq("rot_dead", 32'(bus.gnt), 32'h0);
      step(1'b0, 4'b1111, 1'b0);
      check_eq("rot_gnt", 32'(bus.gnt), 32'(1 << (i % 4)));
    end
    step(1'b0, 4'b1111, 1'b1);

    // Wrap: last owner 2, only low requesters -> 0.
    step(1'b0, 4'b0100, 1'b0);
    check_eq("ptr2_gnt", 32'(bus.gnt), 32'h4);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    check_eq("wrap_gnt", 32'(bus.gnt), 32'h1);
    step(1'b0, 4'b0011, 1'b1);
    // Mask: last owner 2, requesters 1 and 3 -> 3.
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b1010, 1'b0);
    check_eq("mask_gnt", 32'(bus.gnt), 32'h8);
    step(1'b0, 4'b0000, 1'b0);

    // Hold: owner 1 keeps requesting while req[3] toggles.
    step(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, {i[0], 3'b010}, 1'b0);
      if (!TIMEOUT || i < MAX_HOLD - 1)
        check_eq("hold_gnt", 32'(bus.gnt), 32'h2);
    end
    step(1'b0, 4'b0000, 1'b0);
    check_eq("drop_gnt", 32'(bus.gnt), 32'h0);

    // Reset while owner 3 holds the grant.
    step(1'b0, 4'b1000, 1'b0);
    check_eq("pre_rst_gnt", 32'(bus.gnt), 32'h8);
    step(1'b1, 4'b1000, 1'b0);
    check_eq("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    step(1'b0, 4'b1001, 1'b0);
    check_eq("post_rst_gnt", 32'(bus.gnt), 32'h1);

    // Timeout: owner 0 never releases.
    if (TIMEOUT) begin
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0101, 1'b0);
      for (int i = 0; i < MAX_HOLD - 1; i++) step(1'b0, 4'b0101, 1'b0);
      check_eq("to_held", 32'(bus.gnt), 32'h1);
      step(1'b0, 4'b0101, 1'b0);
      check_eq("to_release", 32'(bus.gnt), 32'h0);
      step(1'b0, 4'b0101, 1'b0);
      check_eq("to_next", 32'(bus.gnt), 32'h4);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] q;
      for (int b = 0; b < W; b++) q[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) q = '0;
      step(($urandom_range(0, 99) == 0), q, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_round_robin_arbiter
`default_nettype wire
